decode_rf_stage: RTL

DECODE_RF_STAGE -- requirements
Module: decode_rf_stage

---
 rtl/decode_rf_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/decode_rf_stage.sv
// ---------------------------------------------------------------------------
// decode_rf_stage
//
// Decode / register-read stage. Extracts the rn, rm and rd register fields
// from the fetched instruction, reads them from an internal register file
// (with PC read-as-pc+8 and same-cycle writeback bypass), detects load-use
// hazards against the execute stage, and presents a registered payload to
// execute through a valid/ready handshake.
//
// Ports
//   clk_i                 clock, all state on rising edge
//   reset_i               synchronous active-high reset
//   pc_i      [DATA_W]    PC of the instruction in decode
//   inst_i    [32]        fetched instruction
//   valid_i               inst_i/pc_i valid
//   ready_o               decode accepts inst_i this cycle
//   flush_i               kill pipeline contents
//   wb_en_i               writeback enable
//   wb_addr_i [AW]        writeback register
//   wb_data_i [DATA_W]    writeback data
//   ex_load_i             execute stage holds a valid load
//   ex_rd_i   [AW]        destination of that load
//   valid_o               output payload valid
//   ready_i               execute accepts payload
//   inst_o    [32]        registered instruction
//   rn/rm/rd_data_o       registered operand data  [DATA_W]
//   rn/rm/rd_addr_o       registered operand addresses [AW]
//   hazard_o              combinational load-use stall indication
// ---------------------------------------------------------------------------
module decode_rf_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [31:0]       inst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic              wb_en_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              ex_load_i,
    input  logic [AW-1:0]     ex_rd_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       inst_o,
    output logic [DATA_W-1:0] rn_data_o,
    output logic [DATA_W-1:0] rm_data_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [AW-1:0]     rn_addr_o,
    output logic [AW-1:0]     rm_addr_o,
    output logic [AW-1:0]     rd_addr_o,
    output logic              hazard_o
);

    localparam logic [AW-1:0] PC_IDX = AW'(NUM_REGS - 1);

    // Entry PC_IDX is never written, so it stays at its reset value and is
    // never selected by a read (PC reads take the pc_i+8 path instead).
    logic [DATA_W-1:0] r_rf [NUM_REGS];

    logic              r_valid;
    logic [31:0]       r_inst;
    logic [DATA_W-1:0] r_rn_data;
    logic [DATA_W-1:0] r_rm_data;
    logic [DATA_W-1:0] r_rd_data;
    logic [AW-1:0]     r_rn_addr;
    logic [AW-1:0]     r_rm_addr;
    logic [AW-1:0]     r_rd_addr;

    logic [AW-1:0]     w_rn_addr;
    logic [AW-1:0]     w_rm_addr;
    logic [AW-1:0]     w_rd_addr;
    logic [DATA_W-1:0] w_rn_data;
    logic [DATA_W-1:0] w_rm_data;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_use_rm;
    logic              w_use_rd;
    logic              w_hazard;
    logic              w_advance;
    logic              w_load;

    // -----------------------------------------------------------------------
    // Field extraction
    // -----------------------------------------------------------------------
    assign w_rn_addr = AW'(inst_i[19:16]);
    assign w_rm_addr = AW'(inst_i[3:0]);
    assign w_rd_addr = AW'(inst_i[15:12]);

    // rm is a source for data-processing encodings; rd is a source only for
    // single-data-transfer stores (L bit clear).
    assign w_use_rm = (inst_i[27:25] == 3'b000);
    assign w_use_rd = (inst_i[27:26] == 2'b01) && !inst_i[20];

    // -----------------------------------------------------------------------
    // Read ports: PC has priority over bypass, bypass over stored value
    // -----------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] f_read(input logic [AW-1:0] a);
        if (a == PC_IDX) begin
            return pc_i + DATA_W'(8);
        end else if (wb_en_i && (wb_addr_i == a)) begin
            return wb_data_i;
        end else begin
            return r_rf[a];
        end
    endfunction

    assign w_rn_data = f_read(w_rn_addr);
    assign w_rm_data = f_read(w_rm_addr);
    assign w_rd_data = f_read(w_rd_addr);

    // -----------------------------------------------------------------------
    // Hazard and handshake
    // -----------------------------------------------------------------------
    always_comb begin
        w_hazard = 1'b0;
        if (valid_i && ex_load_i && (ex_rd_i != PC_IDX)) begin
            w_hazard = (ex_rd_i == w_rn_addr)
                     || (w_use_rm && (ex_rd_i == w_rm_addr))
                     || (w_use_rd && (ex_rd_i == w_rd_addr));
        end
    end

    assign w_advance = !r_valid || ready_i;
    assign w_load    = valid_i && !w_hazard;
    assign ready_o   = flush_i || (w_advance && !w_hazard);
    assign hazard_o  = w_hazard;

    // -----------------------------------------------------------------------
    // Register file write port; writes proceed regardless of stall/flush
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_en_i && (wb_addr_i != PC_IDX)) begin
            r_rf[wb_addr_i] <= wb_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Output payload register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid   <= 1'b0;
            r_inst    <= '0;
            r_rn_data <= '0;
            r_rm_data <= '0;
            r_rd_data <= '0;
            r_rn_addr <= '0;
            r_rm_addr <= '0;
            r_rd_addr <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_valid <= w_load;
            if (w_load) begin
                r_inst    <= inst_i;
                r_rn_data <= w_rn_data;
                r_rm_data <= w_rm_data;
                r_rd_data <= w_rd_data;
                r_rn_addr <= w_rn_addr;
                r_rm_addr <= w_rm_addr;
                r_rd_addr <= w_rd_addr;
            end
        end
    end

    assign valid_o   = r_valid;
    assign inst_o    = r_inst;
    assign rn_data_o = r_rn_data;
    assign rm_data_o = r_rm_data;
    assign rd_data_o = r_rd_data;
    assign rn_addr_o = r_rn_addr;
    assign rm_addr_o = r_rm_addr;
    assign rd_addr_o = r_rd_addr;

endmodule
